// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the per-frame scheduler: stage encodings, plot-port
// owner codes and the default stage watchdog limit.
package frame_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_PIPE   = 3'd3,
    S_BIRD   = 3'd4
  } state_e;

  localparam logic [1:0] PLOT_ERASE = 2'd0;
  localparam logic [1:0] PLOT_PIPE  = 2'd1;
  localparam logic [1:0] PLOT_BIRD  = 2'd2;
  localparam logic [1:0] PLOT_NONE  = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;

  // Which drawing engine owns the shared plot port in a given stage.
  function automatic logic [1:0] plot_owner(input state_e s);
    case (s)
      S_ERASE: plot_owner = PLOT_ERASE;
      S_PIPE:  plot_owner = PLOT_PIPE;
      S_BIRD:  plot_owner = PLOT_BIRD;
      default: plot_owner = PLOT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_sequencer_stage_watchdog.sv
// Per-stage cycle counter: cleared on stage entry, flags expiry when the
// count reaches TIMEOUT_CYCLES-1.
module frame_sequencer_stage_watchdog
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                                clk,
  input  logic                                                resetn,
  input  logic                                                clear_i,
  output logic [((TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1)-1:0] count_o,
  output logic                                                expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Hold at the terminal value so an unserviced expiry never wraps.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (count_q != LAST)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o  = count_q;
  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: erase -> update -> pipe draw -> bird draw, one go/done
// handshake per stage, owning the shared plot-port select.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned FCW            = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic           enable,
  input  logic           erase_done,
  input  logic           update_done,
  input  logic           pipe_done,
  input  logic           bird_done,
  output logic           erase_go,
  output logic           update_go,
  output logic           pipe_go,
  output logic           bird_go,
  output logic [1:0]     plot_sel,
  output logic           busy,
  output logic [FCW-1:0] frame_count,
  output logic [7:0]     overrun_count,
  output logic           timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e         state_q, state_d;
  logic           pending_q, pending_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]     ovr_q, ovr_d;
  logic           terr_q, terr_d;
  logic [3:0]     go_q, go_d;
  logic [1:0]     plot_q, plot_d;
  logic           busy_q, busy_d;

  logic           wd_clear, wd_expire;
  logic [CW-1:0]  wd_count;
  logic           stage_done, done_hit, advance;

  frame_sequencer_stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (wd_clear),
    .count_o (wd_count),
    .expire_o(wd_expire)
  );

  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      S_ERASE:  stage_done = erase_done;
      S_UPDATE: stage_done = update_done;
      S_PIPE:   stage_done = pipe_done;
      S_BIRD:   stage_done = bird_done;
      default:  stage_done = 1'b0;
    endcase
  end

  // A zero watchdog count marks the go cycle, where done is not honoured.
  assign done_hit = stage_done && (wd_count != '0);
  assign advance  = (state_q != S_IDLE) && (done_hit || wd_expire);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    ovr_d       = ovr_q;
    terr_d      = terr_q;

    case (state_q)
      S_IDLE: begin
        if ((frame_tick || pending_q) && enable) begin
          state_d   = S_ERASE;
          pending_d = 1'b0;
        end
      end
      S_ERASE:  if (advance) state_d = S_UPDATE;
      S_UPDATE: if (advance) state_d = S_PIPE;
      S_PIPE:   if (advance) state_d = S_BIRD;
      S_BIRD: begin
        if (advance) begin
          state_d     = S_IDLE;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance && !done_hit)
      terr_d = 1'b1;

    if (state_q != S_IDLE && frame_tick) begin
      if (!pending_q)
        pending_d = 1'b1;
      else if (ovr_q != 8'hFF)
        ovr_d = ovr_q + 1'b1;
    end

    go_d = '0;
    if (state_d != state_q) begin
      case (state_d)
        S_ERASE:  go_d[0] = 1'b1;
        S_UPDATE: go_d[1] = 1'b1;
        S_PIPE:   go_d[2] = 1'b1;
        S_BIRD:   go_d[3] = 1'b1;
        default:  go_d    = '0;
      endcase
    end

    plot_d   = plot_owner(state_d);
    busy_d   = (state_d != S_IDLE);
    wd_clear = (state_d != state_q) || (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      ovr_q       <= '0;
      terr_q      <= 1'b0;
      go_q        <= '0;
      plot_q      <= PLOT_NONE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_q       <= ovr_d;
      terr_q      <= terr_d;
      go_q        <= go_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
    end
  end

  assign erase_go      = go_q[0];
  assign update_go     = go_q[1];
  assign pipe_go       = go_q[2];
  assign bird_go       = go_q[3];
  assign plot_sel      = plot_q;
  assign busy          = busy_q;
  assign frame_count   = frame_cnt_q;
  assign overrun_count = ovr_q;
  assign timeout_err   = terr_q;

endmodule
